mem_stage: RTL and testbench

- Memory-access pipeline stage of the 5-stage MIPS core; sits between the execute stage and the write-back stage.
- Accepts one instruction per cycle from EX and waits for the data-SRAM response on loads and stores.
- Aligns and extends load data.
- Forwards a 71-bit result bus to WB; exports bypass/hazard information to decode.

---
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline.
// Waits for the data-SRAM response, aligns/extends load data and forwards results to WB.
module mem_stage #(
    parameter int ES_BUS_WD = 75,
    parameter int MS_BUS_WD = 71
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [MS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    output logic [4:0]           MS_dest,
    output logic [31:0]          ms_to_ds_result,
    output logic                 ms_res_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ms_valid_q, ms_valid_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic        mem_we_q, mem_we_d;
    logic        gr_we_q, gr_we_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        ms_ready_go;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] final_result;

    // The request-issued flag only steers the FSM, so it is not kept in the pipeline register.
    assign ms_ready_go = (state_q == IDLE) ||
                         (state_q == WAIT && data_sram_data_ok) ||
                         (state_q == HOLD);
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);

    always_comb begin
        ms_valid_d   = ms_valid_q;
        state_d      = state_q;
        ld_op_d      = ld_op_q;
        mem_we_d     = mem_we_q;
        gr_we_d      = gr_we_q;
        dest_d       = dest_q;
        alu_result_d = alu_result_q;
        pc_d         = pc_q;
        rdata_buf_d  = rdata_buf_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
            state_d    = IDLE;
            if (es_to_ms_valid) begin
                ld_op_d      = es_to_ms_bus[74:72];
                mem_we_d     = es_to_ms_bus[70];
                gr_we_d      = es_to_ms_bus[69];
                dest_d       = es_to_ms_bus[68:64];
                alu_result_d = es_to_ms_bus[63:32];
                pc_d         = es_to_ms_bus[31:0];
                state_d      = es_to_ms_bus[71] ? WAIT : IDLE;
            end
        end else if (state_q == WAIT && data_sram_data_ok) begin
            state_d     = HOLD;
            rdata_buf_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            state_q      <= IDLE;
            ld_op_q      <= 3'd0;
            mem_we_q     <= 1'b0;
            gr_we_q      <= 1'b0;
            dest_q       <= 5'd0;
            alu_result_q <= 32'd0;
            pc_q         <= 32'd0;
            rdata_buf_q  <= 32'd0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            state_q      <= state_d;
            ld_op_q      <= ld_op_d;
            mem_we_q     <= mem_we_d;
            gr_we_q      <= gr_we_d;
            dest_q       <= dest_d;
            alu_result_q <= alu_result_d;
            pc_q         <= pc_d;
            rdata_buf_q  <= rdata_buf_d;
        end
    end

    assign ld_data = (state_q == HOLD) ? rdata_buf_q : data_sram_rdata;
    assign ld_half = alu_result_q[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        ld_byte = ld_data[7:0];
        case (alu_result_q[1:0])
            2'd0: ld_byte = ld_data[7:0];
            2'd1: ld_byte = ld_data[15:8];
            2'd2: ld_byte = ld_data[23:16];
            2'd3: ld_byte = ld_data[31:24];
            default: ld_byte = ld_data[7:0];
        endcase
    end

    // Reserved load opcodes fall through to the plain ALU result.
    always_comb begin
        final_result = alu_result_q;
        case (ld_op_q)
            3'd1: final_result = {{24{ld_byte[7]}}, ld_byte};
            3'd2: final_result = {24'd0, ld_byte};
            3'd3: final_result = {{16{ld_half[15]}}, ld_half};
            3'd4: final_result = {16'd0, ld_half};
            3'd5: final_result = ld_data;
            default: final_result = alu_result_q;
        endcase
    end

    assign ms_to_ws_valid  = ms_valid_q && ms_ready_go;
    assign ms_to_ws_bus    = {mem_we_q, gr_we_q, dest_q, final_result, pc_q};
    assign MS_dest         = dest_q & {5{ms_valid_q}};
    assign ms_to_ds_result = final_result;
    assign ms_res_ready    = ms_valid_q && (ld_op_q == 3'd0 || ms_ready_go);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push expected WB bus values,
// a negedge monitor pops and compares each retirement.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [70:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [4:0]  MS_dest;
    logic [31:0] ms_to_ds_result;
    logic        ms_res_ready;

    int checks   = 0;
    int failures = 0;
    logic [70:0] expQ[$];

    mem_stage #(.ES_BUS_WD(75), .MS_BUS_WD(71)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .MS_dest           (MS_dest),
        .ms_to_ds_result   (ms_to_ds_result),
        .ms_res_ready      (ms_res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [74:0] mkBus(input logic [2:0] ld, input logic req, input logic mw,
                                          input logic gw, input logic [4:0] d,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {ld, req, mw, gw, d, alu, pc};
    endfunction

    function automatic logic [70:0] mkExp(input logic mw, input logic gw, input logic [4:0] d,
                                          input logic [31:0] res, input logic [31:0] pc);
        return {mw, gw, d, res, pc};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one instruction from EX for the coming edge and optionally records its WB image.
    task automatic applyStimulus(input logic [74:0] bus, input logic push, input logic [70:0] expBus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        if (push) expQ.push_back(expBus);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every retirement into WB is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL wb_unexpected: got %h expected no retirement", ms_to_ws_bus);
            end else begin
                logic [70:0] e;
                e = expQ.pop_front();
                if (ms_to_ws_bus !== e) begin
                    failures++;
                    $display("[TB] FAIL wb_bus: got %h expected %h", ms_to_ws_bus, e);
                end
            end
        end
    end

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        tick();
        tick();
        checkOutput("rst_ms_to_ws_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        checkOutput("rst_MS_dest", {27'd0, MS_dest}, 32'd0);
        checkOutput("rst_ms_allowin", {31'd0, ms_allowin}, 32'd1);
        checkOutput("rst_ms_res_ready", {31'd0, ms_res_ready}, 32'd0);
        reset = 1'b0;
        tick();

        // ALU op, one-cycle visibility
        applyStimulus(mkBus(3'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'hBFC0_0000), 1'b1,
                      mkExp(1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'hBFC0_0000));
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        checkOutput("alu_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        checkOutput("alu_MS_dest", {27'd0, MS_dest}, 32'd5);
        checkOutput("alu_res_ready", {31'd0, ms_res_ready}, 32'd1);
        tick();

        // lb from byte 3, response two cycles after acceptance
        applyStimulus(mkBus(3'd1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0003, 32'hBFC0_0004), 1'b1,
                      mkExp(1'b0, 1'b1, 5'd7, 32'hFFFF_FF80, 32'hBFC0_0004));
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        checkOutput("lb_wait_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        checkOutput("lb_wait_res_ready", {31'd0, ms_res_ready}, 32'd0);
        checkOutput("lb_wait_allowin", {31'd0, ms_allowin}, 32'd0);
        checkOutput("lb_wait_MS_dest", {27'd0, MS_dest}, 32'd7);
        tick();
        checkOutput("lb_wait2_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_FF7F;
        #1;
        checkOutput("lb_ok_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        checkOutput("lb_ok_res_ready", {31'd0, ms_res_ready}, 32'd1);
        checkOutput("lb_bypass", ms_to_ds_result, 32'hFFFF_FF80);
        tick();
        data_sram_data_ok = 1'b0;

        // lhu then lh on the upper halfword
        applyStimulus(mkBus(3'd4, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0002, 32'hBFC0_0008), 1'b1,
                      mkExp(1'b0, 1'b1, 5'd8, 32'h0000_8001, 32'hBFC0_0008));
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_0000;
        tick();
        data_sram_data_ok = 1'b0;
        applyStimulus(mkBus(3'd3, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0002, 32'hBFC0_000C), 1'b1,
                      mkExp(1'b0, 1'b1, 5'd8, 32'hFFFF_8001, 32'hBFC0_000C));
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;

        // lw with WB stalled: HOLD keeps the first response, later pulses are ignored
        applyStimulus(mkBus(3'd5, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0100, 32'hBFC0_0010), 1'b1,
                      mkExp(1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'hBFC0_0010));
        tick();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        checkOutput("hold_allowin", {31'd0, ms_allowin}, 32'd0);
        checkOutput("hold_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        checkOutput("hold_data", ms_to_ds_result, 32'hDEAD_BEEF);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("hold_ignore_ok", ms_to_ds_result, 32'hDEAD_BEEF);
        ws_allowin = 1'b1;
        tick();
        checkOutput("hold_drained", {31'd0, ms_to_ws_valid}, 32'd0);

        // lw followed by ALU op with data_ok on the hand-off cycle: no bubble
        applyStimulus(mkBus(3'd5, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0200, 32'hBFC0_0014), 1'b1,
                      mkExp(1'b0, 1'b1, 5'd10, 32'hCAFE_F00D, 32'hBFC0_0014));
        tick();
        applyStimulus(mkBus(3'd0, 1'b0, 1'b0, 1'b1, 5'd11, 32'h0000_0042, 32'hBFC0_0018), 1'b1,
                      mkExp(1'b0, 1'b1, 5'd11, 32'h0000_0042, 32'hBFC0_0018));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        checkOutput("b2b_allowin", {31'd0, ms_allowin}, 32'd1);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        checkOutput("b2b_second_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        checkOutput("b2b_MS_dest", {27'd0, MS_dest}, 32'd11);
        tick();

        // Store waits for data_ok yet its result is bypass-ready; reserved ld_op 6 acts as ALU
        applyStimulus(mkBus(3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0300, 32'hBFC0_001C), 1'b1,
                      mkExp(1'b1, 1'b0, 5'd0, 32'h0000_0300, 32'hBFC0_001C));
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        checkOutput("st_wait_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        checkOutput("st_res_ready", {31'd0, ms_res_ready}, 32'd1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_FFFF;
        tick();
        data_sram_data_ok = 1'b0;
        applyStimulus(mkBus(3'd6, 1'b0, 1'b0, 1'b1, 5'd12, 32'h8765_4321, 32'hBFC0_0020), 1'b1,
                      mkExp(1'b0, 1'b1, 5'd12, 32'h8765_4321, 32'hBFC0_0020));
        tick();
        es_to_ms_valid = 1'b0;
        tick();

        // Reset while waiting abandons the load; a late data_ok lands in IDLE
        applyStimulus(mkBus(3'd5, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_0400, 32'hBFC0_0024), 1'b0, '0);
        tick();
        es_to_ms_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset             = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_5555;
        #1;
        checkOutput("rstw_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        checkOutput("rstw_allowin", {31'd0, ms_allowin}, 32'd1);
        checkOutput("rstw_res_ready", {31'd0, ms_res_ready}, 32'd0);
        tick();
        data_sram_data_ok = 1'b0;
        checkOutput("rstw_valid_after", {31'd0, ms_to_ws_valid}, 32'd0);
        checkOutput("rstw_MS_dest", {27'd0, MS_dest}, 32'd0);
        tick();
        tick();

        checkOutput("scoreboard_empty", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
